// File: rtl/dsd_pkg.sv
// Shared definitions for the digital signal decoder front end: aligner states,
// default word width and sync pattern, and a counter-width helper.
package dsd_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } dsd_state_t;

  localparam int DSD_DATA_W = 8;
  localparam logic [DSD_DATA_W-1:0] DSD_SYNC_WORD = 8'hA5;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsd_out_reg.sv
// One-entry valid/ready output register. A completed word is loaded when the
// slot is empty or is being emptied in the same cycle; otherwise the word is
// dropped and overflow pulses for one cycle.
module dsd_out_reg
  import dsd_pkg::*;
#(
  parameter int DATA_W = DSD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_first,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              first_word,
  output logic              overflow
);

  logic accept;
  logic can_load;
  logic do_load;

  assign accept   = data_valid && data_ready;
  assign can_load = !data_valid || data_ready;
  assign do_load  = load && can_load;

  // Load, hold or drain the single entry; flag words that find it occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      first_word <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= load && !can_load;
      if (do_load) begin
        data_out   <= load_data;
        first_word <= load_first;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_aligner.sv
// Serial frame aligner: deserialises an MSB-first qualified bit stream, hunts
// for the sync word and slices the following FRAME_LEN words into the output
// register for the decoder.
module serial_frame_aligner
  import dsd_pkg::*;
#(
  parameter int                DATA_W    = DSD_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD = DSD_SYNC_WORD,
  parameter int                FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              serial_valid,
  output logic [DATA_W-1:0] encoded_data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              first_word,
  output logic              locked,
  output logic              overflow
);

  localparam int BC_W = $clog2(DATA_W);
  localparam int WC_W = cnt_width(FRAME_LEN);
  localparam int FC_W = $clog2(DATA_W + 1);

  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_LEN - 1);
  localparam logic [FC_W-1:0] FILL_MAX  = FC_W'(DATA_W);
  localparam logic [FC_W-1:0] FILL_CMP  = FC_W'(DATA_W - 1);

  logic [1:0]        rst_pipe;
  logic              rst_sync_n;
  dsd_state_t        state;
  // Only the low DATA_W-1 bits of the shift register are ever observed: the
  // full DATA_W-bit view is always {shreg, serial_in}, so the bit that would
  // fall off the top is not stored.
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] next_word;
  logic [FC_W-1:0]   fill_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic              word_done;
  logic              word_first;

  assign rst_sync_n = rst_pipe[1];
  assign next_word  = {shreg, serial_in};
  assign word_done  = (state == LOCK) && serial_valid && (bit_cnt == BIT_LAST);
  assign word_first = (word_cnt == '0);

  // Reset synchroniser: asserts immediately, releases two edges after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  // Sync hunt, bit/word counting and lock tracking, advancing on qualified bits only.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= HUNT;
      shreg    <= '0;
      fill_cnt <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      locked   <= 1'b0;
    end else if (serial_valid) begin
      shreg <= next_word[DATA_W-2:0];
      case (state)
        HUNT: begin
          if (fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + 1'b1;
          end
          if ((fill_cnt >= FILL_CMP) && (next_word == SYNC_WORD)) begin
            state    <= LOCK;
            locked   <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        LOCK: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (word_cnt == WORD_LAST) begin
              state    <= HUNT;
              locked   <= 1'b0;
              fill_cnt <= '0;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

  dsd_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_sync_n),
    .load       (word_done),
    .load_data  (next_word),
    .load_first (word_first),
    .data_ready (data_ready),
    .data_out   (encoded_data_out),
    .data_valid (data_valid),
    .first_word (first_word),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Directed self-checking bench for serial_frame_aligner (DATA_W=8,
// SYNC_WORD=8'hA5, FRAME_LEN=4).
module tb_serial_frame_aligner;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic       serial_valid;
  logic [7:0] encoded_data_out;
  logic       data_valid;
  logic       data_ready;
  logic       first_word;
  logic       locked;
  logic       overflow;

  int n_checks;
  int n_fail;
  int ovf_pulses;

  serial_frame_aligner #(
    .DATA_W(8),
    .SYNC_WORD(8'hA5),
    .FRAME_LEN(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .serial_in        (serial_in),
    .serial_valid     (serial_valid),
    .encoded_data_out (encoded_data_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .first_word       (first_word),
    .locked           (locked),
    .overflow         (overflow)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic b, input logic v);
    @(negedge clk);
    serial_in    = b;
    serial_valid = v;
    @(posedge clk);
    #1;
    if (overflow === 1'b1) ovf_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // Send a word MSB first; in gapped mode an unqualified cycle with the
  // opposite bit value follows each bit but the last, and the edge of the
  // 7th qualified bit must not yet show a word.
  task automatic send_word(input logic [7:0] w, input bit gapped, input string tag);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(w[i], 1'b1);
      if (gapped && i == 1) checkOutput({tag, "_valid_before_last_bit"}, 32'(data_valid), 32'd0);
      if (gapped && i != 0) applyStimulus(~w[i], 1'b0);
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] w, input logic first_exp);
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'd1);
    checkOutput({tag, "_data"},  32'(encoded_data_out), 32'(w));
    checkOutput({tag, "_first"}, 32'(first_word), 32'(first_exp));
  endtask

  logic [7:0] payload [4];

  initial begin
    payload[0] = 8'h3C;
    payload[1] = 8'h01;
    payload[2] = 8'hFF;
    payload[3] = 8'h80;
    n_checks     = 0;
    n_fail       = 0;
    ovf_pulses   = 0;
    rst_n        = 1'b0;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    data_ready   = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data",   32'(encoded_data_out), 32'd0);
    checkOutput("rst_valid",  32'(data_valid), 32'd0);
    checkOutput("rst_first",  32'(first_word), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_ovf",    32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Scenario 1: clean sync then four words with data_ready high.
    $display("[TB] clean frame");
    ovf_pulses = 0;
    send_word(8'hA5, 1'b0, "s1_sync");
    checkOutput("s1_locked", 32'(locked), 32'd1);
    checkOutput("s1_novalid", 32'(data_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      send_word(payload[k], 1'b0, "s1");
      check_word($sformatf("s1_w%0d", k), payload[k], (k == 0));
      checkOutput($sformatf("s1_w%0d_locked", k), 32'(locked), (k == 3) ? 32'd0 : 32'd1);
    end
    checkOutput("s1_ovf_count", 32'(ovf_pulses), 32'd0);
    idle(2);
    checkOutput("s1_drained", 32'(data_valid), 32'd0);

    // Scenario 2: junk 101 before the sync word.
    $display("[TB] junk before sync");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 7; i >= 1; i--) applyStimulus(payload[0][0] ^ payload[0][0] ^ ((8'hA5 >> i) & 8'h01) != 0, 1'b1);
    checkOutput("s2_not_yet_locked", 32'(locked), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("s2_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) begin
      send_word(payload[k], 1'b0, "s2");
      if (k == 0) check_word("s2_w0", payload[0], 1'b1);
    end
    checkOutput("s2_unlocked", 32'(locked), 32'd0);
    idle(2);

    // Scenario 3: data_ready low throughout, first word held, three drops.
    $display("[TB] stalled decoder");
    data_ready = 1'b0;
    ovf_pulses = 0;
    send_word(8'hA5, 1'b0, "s3_sync");
    send_word(payload[0], 1'b0, "s3");
    check_word("s3_w0", payload[0], 1'b1);
    send_word(payload[1], 1'b0, "s3");
    checkOutput("s3_ovf_w1", 32'(overflow), 32'd1);
    send_word(payload[2], 1'b0, "s3");
    send_word(payload[3], 1'b0, "s3");
    checkOutput("s3_locked_fall", 32'(locked), 32'd0);
    idle(1);
    checkOutput("s3_ovf_count", 32'(ovf_pulses), 32'd3);
    check_word("s3_held", payload[0], 1'b1);
    data_ready = 1'b1;
    idle(2);
    checkOutput("s3_drained", 32'(data_valid), 32'd0);

    // Scenario 4: serial_valid toggling every cycle.
    $display("[TB] gapped stream");
    ovf_pulses = 0;
    send_word(8'hA5, 1'b1, "s4_sync");
    checkOutput("s4_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_word(payload[k], 1'b1, $sformatf("s4_w%0d", k));
      check_word($sformatf("s4_w%0d", k), payload[k], (k == 0));
      applyStimulus(1'b1, 1'b0);
    end
    checkOutput("s4_unlocked", 32'(locked), 32'd0);
    checkOutput("s4_ovf_count", 32'(ovf_pulses), 32'd0);
    idle(2);

    // Scenario 5: reset after 12 payload bits, then relock.
    $display("[TB] mid-frame reset");
    data_ready = 1'b0;
    send_word(8'hA5, 1'b0, "s5_sync");
    send_word(payload[0], 1'b0, "s5");
    for (int i = 7; i >= 4; i--) applyStimulus(payload[1][i], 1'b1);
    checkOutput("s5_pre_valid", 32'(data_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_valid",  32'(data_valid), 32'd0);
    checkOutput("s5_rst_data",   32'(encoded_data_out), 32'd0);
    checkOutput("s5_rst_first",  32'(first_word), 32'd0);
    checkOutput("s5_rst_locked", 32'(locked), 32'd0);
    checkOutput("s5_rst_ovf",    32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    data_ready = 1'b1;
    idle(3);
    send_word(8'hA5, 1'b0, "s5_resync");
    checkOutput("s5_relocked", 32'(locked), 32'd1);
    send_word(payload[0], 1'b0, "s5");
    check_word("s5_w0", payload[0], 1'b1);
    send_word(payload[1], 1'b0, "s5");
    check_word("s5_w1", payload[1], 1'b0);
    send_word(payload[2], 1'b0, "s5");
    send_word(payload[3], 1'b0, "s5");
    idle(2);

    // Scenario 6: data_ready pulsed exactly on the edge a new word loads.
    $display("[TB] accept and load together");
    data_ready = 1'b0;
    ovf_pulses = 0;
    send_word(8'hA5, 1'b0, "s6_sync");
    send_word(payload[0], 1'b0, "s6");
    check_word("s6_w0", payload[0], 1'b1);
    for (int i = 7; i >= 1; i--) applyStimulus(payload[1][i], 1'b1);
    checkOutput("s6_still_old", 32'(encoded_data_out), 32'h3C);
    data_ready = 1'b1;
    applyStimulus(payload[1][0], 1'b1);
    data_ready = 1'b0;
    check_word("s6_w1", payload[1], 1'b0);
    checkOutput("s6_no_ovf", 32'(overflow), 32'd0);
    data_ready = 1'b1;
    send_word(payload[2], 1'b0, "s6");
    send_word(payload[3], 1'b0, "s6");
    checkOutput("s6_ovf_count", 32'(ovf_pulses), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_aligner.md
# serial_frame_aligner

Upstream stage of the digital signal decoder. It deserialises a qualified MSB-first serial bit stream and hunts for a sync word. Once locked, it slices the following FRAME_LEN words into DATA_W-bit encoded words. Each word is delivered to the decoder over a valid/ready handshake.

## Interface
- DATA_W, 8, encoded word width; equals the decoder's input width
- SYNC_WORD, 8'hA5, DATA_W-bit frame sync pattern; not forwarded
- FRAME_LEN, 4, payload words per frame, ≥1
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- serial_in  input  1  serial data bit, MSB of each word first
- serial_valid  input  1  serial_in qualifier; only qualified cycles shift
- encoded_data_out  output  DATA_W  payload word to decoder
- data_valid  output  1  encoded_data_out valid
- data_ready  input  1  decoder accepts word when data_valid high
- first_word  output  1  sideband with data_valid: word is payload index 0
- locked  output  1  high while in LOCK
- overflow  output  1  one-cycle pulse: completed word dropped

## Operation
- The shift register is DATA_W bits. On each serial_valid cycle: shreg <= {shreg[DATA_W-2:0], serial_in}.
- fill_cnt counts qualified bits in HUNT and saturates at DATA_W. It is cleared on entry to HUNT.
- State HUNT:
  - Compare {shreg[DATA_W-2:0], serial_in} to SYNC_WORD on each serial_valid cycle with fill_cnt ≥ DATA_W-1.
  - On match: go to LOCK and clear bit_cnt and word_cnt.
  - Overlapping patterns are detected; the sync may start at any bit.
- State LOCK:
  - bit_cnt counts 0..DATA_W-1 on serial_valid.
  - At bit_cnt==DATA_W-1, a word is complete: the value is {shreg[DATA_W-2:0], serial_in}.
  - The completed word is offered to the output register with first_word = (word_cnt==0).
  - word_cnt increments per completed word.
  - When the word with word_cnt==FRAME_LEN-1 completes: go to HUNT and clear fill_cnt.
- Output register (one entry):
  - Load the word if data_valid==0, or if data_valid && data_ready in the same cycle (simultaneous accept and load keeps data_valid high).
  - Otherwise the word is dropped, overflow pulses for one cycle, and word_cnt still advances, so frame alignment is kept.
  - data_valid clears on data_valid && data_ready with no load.
- Bits with serial_valid==0 are ignored in all states. Counters and shreg hold.
- Widths:
  - bit_cnt is $clog2(DATA_W) bits.
  - word_cnt is max(1,$clog2(FRAME_LEN)) bits.
  - Counters never wrap outside their legal range.
- FRAME_LEN==1: every payload word has first_word=1, and the block returns to HUNT after each word.

## Timing
- Reset (async assert, sync-to-clk deassert by the top):
  - state=HUNT; shreg=0, fill_cnt=0, bit_cnt=0, word_cnt=0.
  - encoded_data_out=0, data_valid=0, first_word=0, locked=0, overflow=0.
- Reset mid-frame aborts immediately: a pending word is discarded and data_valid drops asynchronously.
- Sync-to-lock latency: locked rises on the clk edge sampling the last sync bit.
- Word latency: data_valid rises on the clk edge that samples the word's last bit. Data is visible the same cycle as the updated register.
- locked falls on the edge sampling the last bit of payload word FRAME_LEN-1. That word's data_valid rises on the same edge.
- Throughput: at most one word per DATA_W qualified cycles. With data_ready tied high, overflow never fires.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package dsd_pkg holds:
  - the state enum (HUNT, LOCK);
  - DSD_DATA_W=8 and DSD_SYNC_WORD=8'hA5 defaults, shared with digital signal decoder instances.
- Sub-module dsd_out_reg holds the one-entry valid/ready output register, with load/drop/overflow logic and parameter DATA_W.
- Sync detection and counters are inline in serial_frame_aligner.

## Test plan
- Reset, then 8 serial_valid bits of 8'hA5 followed by payload 8'h3C, 8'h01, 8'hFF, 8'h80 with data_ready=1 → four words in order. first_word is 1 only on 8'h3C. locked falls with 8'h80, and overflow stays 0.
- Junk bits 3'b101 before 8'hA5 → lock still acquired at the correct bit. The first payload word matches bit-exact.
- Same frame with data_ready=0 throughout → first word 8'h3C is held. overflow pulses three times (for 8'h01, 8'hFF and 8'h80). encoded_data_out stays 8'h3C.
- serial_valid toggling 1/0 every cycle during a frame → identical words to the first scenario. Each data_valid occurs on the edge sampling the 8th qualified bit.
- rst_n asserted after 12 payload bits → all outputs zero at once. A new sync afterwards locks normally with word_cnt restarting at 0.
- data_ready pulsed exactly in the cycle a new word loads → old word accepted and new word loaded, data_valid stays 1 and no overflow.
